mem_access_unit: RTL and testbench

- Memory stage placed directly downstream of the EX/MEM pipeline register.
- Takes the registered ALU address, store data, func3, MemRead and MemWrite, and runs a req/ack transaction on the data-memory bus.
- Formats store bytes and byte-enables from func3 and aligns/sign-extends load data.
- Drives mem_stall, which holds the EX/MEM register (its write input) until the access completes.

---
 rtl/mem_access_unit_pkg.sv | 56 +++++
 rtl/mem_access_unit_load_align.sv | 45 ++++
 rtl/mem_access_unit.sv | 192 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_unit_pkg.sv
// mem_access_unit_pkg: func3 codes, FSM state type and access-size helpers
// shared by the memory-stage RTL.
package mem_access_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mau_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } acc_size_e;

  // Stores only know SB/SH explicitly (everything else is a word); loads
  // decode size from func3[1:0] so that LBU/LHU share the LB/LH sizes.
  function automatic acc_size_e access_size(input logic [2:0] func3,
                                            input logic       is_store);
    acc_size_e sz;
    if (is_store) begin
      case (func3)
        F3_B:    sz = SZ_BYTE;
        F3_H:    sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end else begin
      case (func3[1:0])
        2'b00:   sz = SZ_BYTE;
        2'b01:   sz = SZ_HALF;
        default: sz = SZ_WORD;
      endcase
    end
    return sz;
  endfunction

  // Address is misaligned when it has set bits below the access size.
  function automatic logic is_misaligned(input acc_size_e  sz,
                                         input logic [1:0] a);
    logic mis;
    case (sz)
      SZ_HALF: mis = a[0];
      SZ_WORD: mis = (a != 2'b00);
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// load_align: selects the addressed byte/halfword of a read word and
// sign- or zero-extends it according to func3. Purely combinational.
module load_align
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  a_i,
  input  logic [2:0]  func3_i,
  output logic [31:0] data_o
);

  function automatic logic [31:0] ext8(input logic [7:0] b, input logic sgn);
    return sgn ? {{24{b[7]}}, b} : {24'h0, b};
  endfunction

  function automatic logic [31:0] ext16(input logic [15:0] h, input logic sgn);
    return sgn ? {{16{h[15]}}, h} : {16'h0, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select for byte and halfword views of the read word
  always_comb begin
    case (a_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // Extension by func3; unlisted codes return the full word
  always_comb begin
    case (func3_i)
      F3_B:    data_o = ext8(byte_sel, 1'b1);
      F3_BU:   data_o = ext8(byte_sel, 1'b0);
      F3_H:    data_o = ext16(half_sel, 1'b1);
      F3_HU:   data_o = ext16(half_sel, 1'b0);
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory stage behind EX/MEM. Runs one req/ack bus
// transaction per load/store, formats store lanes, aligns load data and
// stalls EX/MEM until the access retires.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word
// accesses (no bus request, misalign_out pulses with mem_done).
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] ALU_in,
  input  logic [31:0]           reg2_data_in,
  input  logic [2:0]            func3_in,
  input  logic                  MemRead_in,
  input  logic                  MemWrite_in,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]           dmem_wdata,
  output logic [3:0]            dmem_be,
  input  logic                  dmem_ack,
  input  logic [31:0]           dmem_rdata,
  output logic [31:0]           load_data,
  output logic                  mem_stall,
  output logic                  mem_done
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                  misalign_out
`endif
);

  function automatic logic [3:0] store_be(input acc_size_e sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      SZ_BYTE: be = 4'b0001 << a;
      SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] store_wdata(input acc_size_e sz, input logic [31:0] d);
    logic [31:0] wd;
    case (sz)
      SZ_BYTE: wd = {4{d[7:0]}};
      SZ_HALF: wd = {2{d[15:0]}};
      default: wd = d;
    endcase
    return wd;
  endfunction

  mau_state_e            state_q, state_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [3:0]            be_q, be_d;
  logic [31:0]           load_q, load_d;
  logic                  done_q, done_d;
  logic                  is_load_q, is_load_d;
  logic [1:0]            a_q, a_d;
  logic [2:0]            f3_q, f3_d;
`ifdef MEM_MISALIGN_TRAP_EN
  logic                  mis_q, mis_d;
`endif

  logic       acc;
  acc_size_e  sz;
  logic [31:0] load_fmt;

  assign acc = MemRead_in | MemWrite_in;
  // A simultaneous read+write request is a store, so size follows MemWrite.
  assign sz  = access_size(func3_in, MemWrite_in);

  // Alignment of the returning word uses the offset/func3 captured at request
  load_align u_load_align (
    .rdata_i (dmem_rdata),
    .a_i     (a_q),
    .func3_i (f3_q),
    .data_o  (load_fmt)
  );

  // Next-state and registered bus-field computation
  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    load_d    = load_q;
    done_d    = 1'b0;
    is_load_d = is_load_q;
    a_d       = a_q;
    f3_d      = f3_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d     = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (acc) begin
`ifdef MEM_MISALIGN_TRAP_EN
          if (is_misaligned(sz, ALU_in[1:0])) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else
`endif
          begin
            req_d     = 1'b1;
            we_d      = MemWrite_in;
            addr_d    = {ALU_in[ADDR_WIDTH-1:2], 2'b00};
            wdata_d   = store_wdata(sz, reg2_data_in);
            be_d      = MemWrite_in ? store_be(sz, ALU_in[1:0]) : 4'b1111;
            is_load_d = ~MemWrite_in;
            a_d       = ALU_in[1:0];
            f3_d      = func3_in;
            state_d   = WAIT;
          end
        end
      end
      WAIT: begin
        if (dmem_ack) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
          if (is_load_q) begin
            load_d = load_fmt;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any transaction in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      load_q    <= '0;
      done_q    <= 1'b0;
      is_load_q <= 1'b0;
      a_q       <= '0;
      f3_q      <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      load_q    <= load_d;
      done_q    <= done_d;
      is_load_q <= is_load_d;
      a_q       <= a_d;
      f3_q      <= f3_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q     <= mis_d;
`endif
    end
  end

  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign dmem_be    = be_q;
  assign load_data  = load_q;
  assign mem_done   = done_q;
  // DONE deasserts stall so EX/MEM advances exactly once per access.
  assign mem_stall  = ((state_q == IDLE) && acc) || (state_q == WAIT);
`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_out = mis_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed and randomized load/store transactions
// checked against a byte-lane reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] ALU_in;
  logic [31:0] reg2_data_in;
  logic [2:0]  func3_in;
  logic        MemRead_in;
  logic        MemWrite_in;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] load_data;
  logic        mem_stall;
  logic        mem_done;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign_out;
`endif

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_load;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .ALU_in       (ALU_in),
    .reg2_data_in (reg2_data_in),
    .func3_in     (func3_in),
    .MemRead_in   (MemRead_in),
    .MemWrite_in  (MemWrite_in),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_wdata   (dmem_wdata),
    .dmem_be      (dmem_be),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .load_data    (load_data),
    .mem_stall    (mem_stall),
    .mem_done     (mem_done)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .misalign_out (misalign_out)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  function automatic int acc_bytes(input logic [2:0] f3, input logic st);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    return (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
  endfunction

  function automatic int lane_off(input int sz, input logic [1:0] a);
    return (sz == 4) ? 0 : (int'(a) / sz) * sz;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input logic [2:0] f3,
                                             input logic [1:0] a);
    int sz;
    int off;
    logic [31:0] v;
    logic [31:0] mask;
    sz  = acc_bytes(f3, 1'b0);
    off = lane_off(sz, a);
    if (sz == 4) return rdata;
    mask = (32'h1 << (8 * sz)) - 32'h1;
    v = (rdata >> (8 * off)) & mask;
    if (!f3[2] && v[8*sz-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic model_mis(input int sz, input logic [1:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
    return (sz == 2 && a[0]) || (sz == 4 && a != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  // One access from presentation in IDLE through the cycle after DONE.
  task automatic do_access(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [2:0] f3, input logic [31:0] reg2,
                           input logic [31:0] rdata, input int dly);
    int sz;
    int off;
    int stalls;
    int reqs;
    logic done;
    logic mis;
    logic [31:0] ebe;
    logic [31:0] ewd;
    sz  = acc_bytes(f3, wr);
    off = lane_off(sz, addr[1:0]);
    mis = model_mis(sz, addr[1:0]);
    ebe = wr ? (32'((1 << sz) - 1) << off) : 32'hF;
    for (int i = 0; i < 4; i++) ewd[8*i +: 8] = reg2[8*(i % sz) +: 8];
    if (rd && !wr && !mis) exp_load = model_load(rdata, f3, addr[1:0]);

    @(negedge clk);
    MemRead_in = rd; MemWrite_in = wr; ALU_in = addr; func3_in = f3;
    reg2_data_in = reg2; dmem_ack = 1'b0;
    stalls = 0; reqs = 0; done = 1'b0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (mem_stall) stalls++;
      if (mem_done) begin
        done = 1'b1;
        check("load_data", load_data, exp_load);
`ifdef MEM_MISALIGN_TRAP_EN
        check("misalign_out", 32'(misalign_out), 32'(mis));
`endif
        dmem_ack = 1'($urandom_range(0, 1));
      end else if (dmem_req) begin
        reqs++;
        check("addr", dmem_addr, addr & 32'hFFFF_FFFC);
        check("we", 32'(dmem_we), 32'(wr));
        check("be", 32'(dmem_be), ebe);
        if (wr) check("wdata", dmem_wdata, ewd);
        if (reqs == dly) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
      end
      @(negedge clk);
      dmem_ack = 1'b0;
      dmem_rdata = $urandom;
    end
    check("done_seen", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), mis ? 32'd1 : 32'(1 + dly));
    check("req_cycles", 32'(reqs), mis ? 32'd0 : 32'(dly));
    // First IDLE cycle after DONE: drop the request, inject a stray ack.
    MemRead_in = 1'b0; MemWrite_in = 1'b0;
    dmem_ack = 1'($urandom_range(0, 1));
    #1;
    check("done_pulse_width", 32'(mem_done), 32'd0);
    check("idle_stall", 32'(mem_stall), 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
    check("misalign_width", 32'(misalign_out), 32'd0);
`endif
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("stray_ack_done", 32'(mem_done), 32'd0);
    check("stray_ack_req", 32'(dmem_req), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    ALU_in = '0; reg2_data_in = '0; func3_in = '0;
    MemRead_in = 1'b0; MemWrite_in = 1'b0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    exp_load = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", 32'(dmem_req), 32'd0);
    check("rst_we", 32'(dmem_we), 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_be", 32'(dmem_be), 32'd0);
    check("rst_load", load_data, 32'd0);
    check("rst_done", 32'(mem_done), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Directed cases
    do_access(1'b1, 1'b0, 32'h100, 3'b010, 32'h0, 32'hDEADBEEF, 3);
    check("lw_value", load_data, 32'hDEADBEEF);
    do_access(1'b1, 1'b0, 32'h103, 3'b000, 32'h0, 32'h80FF1234, 1);
    check("lb_value", load_data, 32'hFFFFFF80);
    do_access(1'b1, 1'b0, 32'h103, 3'b100, 32'h0, 32'h80FF1234, 2);
    check("lbu_value", load_data, 32'h00000080);
    do_access(1'b0, 1'b1, 32'h202, 3'b000, 32'h000000A5, 32'h0, 1);
    do_access(1'b0, 1'b1, 32'h202, 3'b001, 32'h0000BEEF, 32'h0, 2);
    do_access(1'b1, 1'b1, 32'h202, 3'b001, 32'h0000BEEF, 32'h12345678, 2);
    check("rd_wr_is_store", load_data, 32'h00000080);
    do_access(1'b1, 1'b0, 32'h102, 3'b001, 32'h0, 32'h8001C0DE, 1);
    do_access(1'b1, 1'b0, 32'h101, 3'b010, 32'h0, 32'hCAFEF00D, 2);

    // Reset asserted while waiting for ack
    @(negedge clk);
    MemRead_in = 1'b1; MemWrite_in = 1'b0; ALU_in = 32'h300; func3_in = 3'b010;
    @(negedge clk);
    #1;
    check("wait_req_before_rst", 32'(dmem_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_req", 32'(dmem_req), 32'd0);
    check("async_rst_addr", dmem_addr, 32'd0);
    check("async_rst_be", 32'(dmem_be), 32'd0);
    check("async_rst_load", load_data, 32'd0);
    MemRead_in = 1'b0;
    #1;
    check("async_rst_idle", 32'(mem_stall), 32'd0);
    exp_load = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b1; dmem_rdata = 32'hBAD0BAD0;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("stale_ack_done", 32'(mem_done), 32'd0);
    check("stale_ack_load", load_data, 32'd0);
    @(negedge clk);
    #1;
    check("stale_ack_done2", 32'(mem_done), 32'd0);

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      logic rd;
      logic wr;
      int   k;
      k  = $urandom_range(0, 2);
      rd = (k != 1);
      wr = (k != 0);
      do_access(rd, wr, $urandom & 32'h0000_0FFF, 3'($urandom_range(0, 7)),
                $urandom, $urandom, $urandom_range(1, 4));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
